// File: rtl/reg_file_if.sv
// Register-file access bundle: decode/writeback side (master) drives addresses
// and write data, the register file (slave) returns the two read words.
interface reg_file_if #(
    parameter int N = 32
) ();
    logic         Reg_Write_i;
    logic [4:0]   Write_Register_i;
    logic [N-1:0] Write_Data_i;
    logic [4:0]   Read_Register_1_i;
    logic [4:0]   Read_Register_2_i;
    logic [N-1:0] Read_Data_1_o;
    logic [N-1:0] Read_Data_2_o;

    modport master (
        output Reg_Write_i,
        output Write_Register_i,
        output Write_Data_i,
        output Read_Register_1_i,
        output Read_Register_2_i,
        input  Read_Data_1_o,
        input  Read_Data_2_o
    );

    modport slave (
        input  Reg_Write_i,
        input  Write_Register_i,
        input  Write_Data_i,
        input  Read_Register_1_i,
        input  Read_Register_2_i,
        output Read_Data_1_o,
        output Read_Data_2_o
    );
endinterface

// File: rtl/reg_file.sv
// 32 x N register file, r0 hardwired to zero, two combinational read ports.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to the reads.
module reg_file #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);
    logic [N-1:0] entry_q [32];
    logic [4:0]   rd_addr [2];
    logic [N-1:0] rd_data [2];

    // r0 has no storage at all, so it can never hold a non-zero value.
    assign entry_q[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_entry
            logic [N-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (bus.Reg_Write_i && (bus.Write_Register_i == 5'(gi))) begin
                    entry_reg <= bus.Write_Data_i;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign rd_addr[0] = bus.Read_Register_1_i;
    assign rd_addr[1] = bus.Read_Register_2_i;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [N-1:0] data_next;

            always_comb begin
                data_next = entry_q[rd_addr[gi]];
`ifdef REG_FILE_BYPASS_EN
                // Write-through: a reader of the register being written sees the new word now.
                if (bus.Reg_Write_i && !reset && (bus.Write_Register_i != 5'd0)
                        && (bus.Write_Register_i == rd_addr[gi])) begin
                    data_next = bus.Write_Data_i;
                end
`endif
            end

            assign rd_data[gi] = data_next;
        end
    endgenerate

    assign bus.Read_Data_1_o = rd_data[0];
    assign bus.Read_Data_2_o = rd_data[1];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array model.
module tb_reg_file;
    localparam int N = 32;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    bit   chk_en;

    logic [N-1:0] model [32];

    reg_file_if #(.N(N)) bus ();

    reg_file #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the array as the rules describe it, updated on every edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
        end else if (bus.Reg_Write_i && bus.Write_Register_i != 5'd0) begin
            model[bus.Write_Register_i] <= bus.Write_Data_i;
        end
    end

    function automatic logic [N-1:0] expect_read(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (bus.Reg_Write_i && !reset && bus.Write_Register_i != 5'd0 && bus.Write_Register_i == a)
            return bus.Write_Data_i;
`endif
        return model[a];
    endfunction

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (chk_en) begin
            check("port1_model", bus.Read_Data_1_o, expect_read(bus.Read_Register_1_i));
            check("port2_model", bus.Read_Data_2_o, expect_read(bus.Read_Register_2_i));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [N-1:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.Reg_Write_i       = we;
        bus.Write_Register_i  = wa;
        bus.Write_Data_i      = wd;
        bus.Read_Register_1_i = ra1;
        bus.Read_Register_2_i = ra2;
    endtask

    task automatic write_reg(input logic [4:0] wa, input logic [N-1:0] wd);
        drive(1'b1, wa, wd, 5'd0, 5'd0);
        tick();
        bus.Reg_Write_i = 1'b0;
        $display("[TB] write r%0d = 0x%08h", wa, wd);
    endtask

    task automatic read_both(input string name, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [N-1:0] e1, input logic [N-1:0] e2);
        bus.Read_Register_1_i = a1;
        bus.Read_Register_2_i = a2;
        #1;
        $display("[TB] read %s: r%0d=0x%08h r%0d=0x%08h", name, a1, bus.Read_Data_1_o, a2, bus.Read_Data_2_o);
        check({name, "_p1"}, bus.Read_Data_1_o, e1);
        check({name, "_p2"}, bus.Read_Data_2_o, e2);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        chk_en       = 1'b0;
        reset        = 1'b1;
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);

        // Before any reset edge, r0 must already read zero.
        #1;
        check("r0_prereset", bus.Read_Data_1_o, '0);
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset clears the whole array.
        write_reg(5'd5, 32'hFFFF_FFFF);
        read_both("r5_written", 5'd5, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("[TB] reset pulse");
        for (int a = 0; a < 32; a++) begin
            read_both("after_reset", 5'(a), 5'(31 - a), '0, '0);
        end

        // Sequential writes and readback.
        write_reg(5'd2, 32'd7);
        write_reg(5'd4, 32'd20);
        write_reg(5'd25, 32'd6);
        write_reg(5'd31, 32'd78);
        read_both("seq_r2", 5'd2, 5'd2, 32'd7, 32'd7);
        read_both("seq_r4", 5'd4, 5'd4, 32'd20, 32'd20);
        read_both("seq_r25", 5'd25, 5'd25, 32'd6, 32'd6);
        read_both("seq_r31", 5'd31, 5'd31, 32'd78, 32'd78);

        // r0 ignores writes.
        write_reg(5'd0, 32'd3);
        read_both("r0_hardwired", 5'd0, 5'd0, '0, '0);

        // Write enable low: nothing changes.
        drive(1'b0, 5'd4, 32'd99, 5'd4, 5'd4);
        repeat (4) tick();
        read_both("we_gated", 5'd4, 5'd4, 32'd20, 32'd20);

        // Independent ports.
        read_both("dual_port", 5'd2, 5'd31, 32'd7, 32'd78);

        // Reset beats a simultaneous write.
        drive(1'b1, 5'd7, 32'h55, 5'd7, 5'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.Reg_Write_i = 1'b0;
        read_both("reset_vs_write", 5'd7, 5'd2, '0, '0);

        // Same-cycle read of the register being written.
        write_reg(5'd9, 32'd1);
        drive(1'b1, 5'd9, 32'h1234, 5'd9, 5'd9);
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("bypass_pre_edge", bus.Read_Data_1_o, 32'h1234);
`else
        check("bypass_pre_edge", bus.Read_Data_1_o, 32'd1);
`endif
        tick();
        bus.Reg_Write_i = 1'b0;
        read_both("bypass_post_edge", 5'd9, 5'd9, 32'h1234, 32'h1234);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa    = 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
            tick();
            $display("[TB] rand %0d: rst=%0b we=%0b wa=%0d wd=0x%08h ra1=%0d ra2=%0d", n, reset,
                     bus.Reg_Write_i, bus.Write_Register_i, bus.Write_Data_i,
                     bus.Read_Register_1_i, bus.Read_Register_2_i);
        end
        reset = 1'b0;
        bus.Reg_Write_i = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file for the 32-bit datapath: 32 registers of N bits, two independent combinational read ports and one synchronous write port. Register 0 is hardwired to zero. It sits between instruction decode (read addresses from rs/rt, write address from rd/rt) and writeback (write data and enable from the control unit).

## Interface

- N, default 32, data width of every register and of the write/read data ports.

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- Reg_Write_i  input  1  write enable; a write is committed on the rising edge when high.
- Write_Register_i  input  5  destination register index, 0–31.
- Write_Data_i  input  N  data to store in the destination register.
- Read_Register_1_i  input  5  read port 1 register index.
- Read_Register_2_i  input  5  read port 2 register index.
- Read_Data_1_o  output  N  contents of the register selected by Read_Register_1_i.
- Read_Data_2_o  output  N  contents of the register selected by Read_Register_2_i.

## Operation

- Storage: 32 entries x N bits, indices 0–31. The 5-bit address covers the full range, so no out-of-range case exists.
- Write: on a rising clk edge with reset=0 and Reg_Write_i=1, Write_Data_i is stored into the entry at Write_Register_i. Only that entry changes.
- Reg_Write_i=0: no entry changes, regardless of address or data.
- Register 0: always reads 0. Writes to index 0 are discarded, and entry 0 is never stored as non-zero.
- Reads: purely combinational. Read_Data_x_o = entry[Read_Register_x_i], or 0 when the index is 0. The two ports are fully independent and may select the same register.
- Reset: on a rising edge with reset=1, all 32 entries clear to 0. Reset has priority over a simultaneous write, which is discarded.
- Both outputs therefore read 0 after reset, for any address.

## Timing

- Write latency: one edge. Data written at edge k is visible on the read ports immediately after edge k, once combinational settling completes.
- Read latency: zero cycles. Outputs follow address and state changes combinationally, with no registered outputs.
- Same-cycle read of the register being written: by default the read returns the old value until the edge. See Configuration for the bypass option.
- Reset mid-operation: any edge with reset=1 clears the whole array, independent of Reg_Write_i. Normal writes resume on the first edge with reset=0.
- Outputs are not forced by reset directly. They reflect the cleared array from the reset edge onward.
- Before the first reset edge, entries 1–31 are undefined. Entry 0 still reads 0.

## Configuration

- REG_FILE_BYPASS_EN defined: write-through forwarding on both read ports. A port returns Write_Data_i combinationally when all of the following hold:
  - Reg_Write_i=1
  - reset=0
  - Write_Register_i != 0
  - Write_Register_i equals that port's read index

  This gives same-cycle visibility for a read in the same cycle as the write.
- REG_FILE_BYPASS_EN undefined: no forwarding. Reads always return stored array contents, so a written value appears only after the write edge.
- Register-0 and reset behaviour are identical in both builds.

## Test plan

- Reset clears: write 0xFFFFFFFF to r5 with reset=0, then hold reset=1 for one edge -> Read_Data_1_o and Read_Data_2_o read 0 at r5 and at every other address.
- Sequential writes and readback: write r2=7, r4=20, r25=6, r31=78 on consecutive edges, then read addresses 2, 4, 25, 31 on both ports -> each port returns 7, 20, 6, 78 in turn.
- Register 0 hardwired: write 3 to r0 with Reg_Write_i=1 -> both ports at address 0 read 0.
- Write-enable gating: with r4=20 stored, set Reg_Write_i=0 and drive r4 with 99 for several edges -> r4 still reads 20.
- Reset vs. write collision and dual-port independence:
  - reset=1 and Reg_Write_i=1 writing r7=0x55 on the same edge -> r7 reads 0.
  - Port 1 reading r2=7 while port 2 reads r31=78 -> 7 and 78 simultaneously.
- Bypass, with REG_FILE_BYPASS_EN: r9 holds 1; drive a write of 0x1234 to r9 with port 1 addressing r9 before the edge -> port 1 shows 0x1234 pre-edge. Without the macro, it shows 1 pre-edge and 0x1234 post-edge.
